sram_port_sched: RTL and testbench



---
 rtl/sram_port_sched.sv | 172 +++++++++++++++++
 tb/tb_sram_port_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_sched.sv
// sram_port_sched: write-priority arbiter with read aging for the shared activation SRAM,
// plus a per-layer write-back counter. Optional stall counters under `define WB_PERF_CNT_EN.
module sram_port_sched #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int AGE_MAX = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              sram_en,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              layer_start,
  input  logic [CNT_W-1:0]  layer_wr_count,
  output logic              layer_done,
  output logic              busy,
  output logic [1:0]        fsm_state
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       wb_stall_cnt,
  output logic [31:0]       rd_stall_cnt
`endif
);

  localparam int AGE_W = $clog2(AGE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [AGE_W-1:0]   age;
  logic               age_full;
  logic               rd_gnt, wr_gnt;
  logic               rd_pend;
  logic               start_acc;
  logic [CNT_W-1:0]   target;
  logic [CNT_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]   wr_cnt_inc;

  // Handshake: a transfer happens when valid && ready in the same cycle. ready is a
  // combinational function of both valids; requesters hold valid and payload until accepted.
  assign age_full = (age == AGE_W'(AGE_MAX));
  assign rd_gnt   = rd_valid && (!wb_valid || age_full);
  assign wr_gnt   = wb_valid && !rd_gnt;
  assign wb_ready = wr_gnt;
  assign rd_ready = rd_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      age <= '0;
    end else if (rd_gnt) begin
      age <= '0;
    end else if (rd_valid && !age_full) begin
      age <= age + AGE_W'(1);
    end
  end

  // Address/data only move on a grant so the bus stays quiet between accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_en    <= 1'b0;
      sram_wen   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_en <= wr_gnt || rd_gnt;
      if (wr_gnt) begin
        sram_wen   <= 1'b1;
        sram_addr  <= wb_addr;
        sram_wdata <= wb_data;
      end else if (rd_gnt) begin
        sram_wen  <= 1'b0;
        sram_addr <= rd_addr;
      end
    end
  end

  // sram_rdata is valid while the read command is on the bus; capture it at that cycle's end.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend       <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_pend       <= rd_gnt;
      rd_data_valid <= rd_pend;
      if (rd_pend) begin
        rd_data <= sram_rdata;
      end
    end
  end

  assign start_acc  = (state == IDLE) && layer_start;
  assign wr_cnt_inc = wr_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      target <= '0;
      wr_cnt <= '0;
    end else begin
      state <= state_n;
      if (start_acc) begin
        target <= layer_wr_count;
        wr_cnt <= '0;
      end else if (state == RUN && wr_gnt) begin
        wr_cnt <= wr_cnt_inc;
      end
    end
  end

  always_comb begin
    state_n    = state;
    layer_done = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (layer_start) begin
          state_n = (layer_wr_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Exit on equality so the counter never passes the target.
        if (wr_gnt && (wr_cnt_inc == target)) begin
          state_n = DRAIN;
        end
      end
      DRAIN: state_n = DONE;
      DONE: begin
        layer_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign fsm_state = state;

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      wb_stall_cnt <= '0;
      rd_stall_cnt <= '0;
    end else begin
      if (wb_valid && !wr_gnt && (wb_stall_cnt != '1)) begin
        wb_stall_cnt <= wb_stall_cnt + 32'd1;
      end
      if (rd_valid && !rd_gnt && (rd_stall_cnt != '1)) begin
        rd_stall_cnt <= rd_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_sched.sv
// Directed bench for sram_port_sched: arbitration, read latency, aging, layer FSM, reset abort.
module tb_sram_port_sched;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int AGE_MAX = 4;
  localparam int CNT_W   = 16;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;

  logic              clk, reset;
  logic              wb_valid, wb_ready, rd_valid, rd_ready;
  logic [ADDR_W-1:0] wb_addr, rd_addr, sram_addr;
  logic [DATA_W-1:0] wb_data, rd_data, sram_wdata, sram_rdata;
  logic              rd_data_valid, sram_en, sram_wen;
  logic              layer_start, layer_done, busy;
  logic [CNT_W-1:0]  layer_wr_count;
  logic [1:0]        fsm_state;
`ifdef WB_PERF_CNT_EN
  logic [31:0]       wb_stall_cnt, rd_stall_cnt;
`endif

  sram_port_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AGE_MAX(AGE_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .layer_start(layer_start), .layer_wr_count(layer_wr_count),
    .layer_done(layer_done), .busy(busy), .fsm_state(fsm_state)
`ifdef WB_PERF_CNT_EN
    , .wb_stall_cnt(wb_stall_cnt), .rd_stall_cnt(rd_stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // SRAM model: write on the clock, read data follows the address on the bus
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (sram_en && sram_wen) mem[sram_addr] <= sram_wdata;
  assign sram_rdata = mem[sram_addr];

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] pre [3] = '{16'h1234, 16'h5678, 16'h9ABC};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_sample();
    logic [DATA_W-1:0] e;
    if (rd_data_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", rd_data, e);
      end
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              exp_rd;
    int                widx;
    reset = 1'b1; wb_valid = 0; wb_addr = '0; wb_data = '0;
    rd_valid = 0; rd_addr = '0; layer_start = 0; layer_wr_count = '0;
    repeat (2) tick();
    #1;
    check("rst_sram", {sram_en, sram_wen, sram_addr, sram_wdata}, 0);
    check("rst_rd", {rd_data_valid, rd_data}, 0);
    check("rst_ctl", {layer_done, busy, fsm_state, wb_ready, rd_ready}, 0);
    reset = 1'b0;

    // write only: three back-to-back writes
    for (int i = 0; i < 4; i++) begin
      tick();
      wb_valid = (i < 3);
      wb_addr  = ADDR_W'(16 + i);
      wb_data  = DATA_W'(32'hAAAA + i);
      #1;
      check("wo_ready", wb_ready, (i < 3));
      if (i > 0) begin
        ea = ADDR_W'(16 + i - 1);
        ed = DATA_W'(32'hAAAA + i - 1);
        check("wo_cmd", {sram_en, sram_wen, sram_addr, sram_wdata}, {1'b1, 1'b1, ea, ed});
      end
    end
    tick(); #1;
    check("wo_idle_en", sram_en, 0);
    check("wo_hold_addr", sram_addr, 10'h012);

    // preload read targets through the write port
    for (int i = 0; i < 3; i++) begin
      tick();
      wb_valid = 1; wb_addr = ADDR_W'(32 + i); wb_data = pre[i];
      #1;
      check("pl_ready", wb_ready, 1);
    end
    tick(); wb_valid = 0;

    // single read latency
    tick(); rd_valid = 1; rd_addr = 10'h020; #1;
    check("rl_rd_ready", rd_ready, 1);
    exp_q.push_back(16'h1234);
    tick(); rd_valid = 0; #1;
    check("rl_cmd", {sram_en, sram_wen, sram_addr}, {1'b1, 1'b0, 10'h020});
    check("rl_dv_t1", rd_data_valid, 0);
    tick(); #1;
    check("rl_dv_t2", rd_data_valid, 1);
    sb_sample();
    tick(); #1;
    check("rl_dv_t3", rd_data_valid, 0);

    // back-to-back reads
    for (int i = 0; i < 6; i++) begin
      tick();
      rd_valid = (i < 3);
      rd_addr  = ADDR_W'(32 + (i % 3));
      #1;
      if (i < 3) begin
        check("b2b_ready", rd_ready, 1);
        exp_q.push_back(pre[i]);
      end
      check("b2b_dv", rd_data_valid, (i >= 2 && i <= 4));
      sb_sample();
    end

    // starvation: both requesters held high
    widx = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      wb_valid = 1; wb_addr = ADDR_W'(256 + widx); wb_data = DATA_W'(32'hC000 + widx);
      rd_valid = 1; rd_addr = 10'h020;
      #1;
      exp_rd = ((i % 5) == 4);
      check("st_rd_ready", rd_ready, exp_rd);
      check("st_wb_ready", wb_ready, !exp_rd);
      if (exp_rd) exp_q.push_back(16'h1234);
      else widx++;
      sb_sample();
    end
    tick(); wb_valid = 0; rd_valid = 0; #1; sb_sample();
    repeat (2) begin tick(); #1; sb_sample(); end
    check("st_q_empty", exp_q.size(), 0);

    // layer of 5 writes with gaps
    tick(); layer_start = 1; layer_wr_count = 5; #1;
    check("l5_busy0", busy, 0);
    tick(); layer_start = 0; #1;
    check("l5_busy1", busy, 1);
    check("l5_run", fsm_state, S_RUN);
    for (int i = 0; i < 9; i++) begin
      tick();
      wb_valid = ((i % 2) == 0); wb_addr = ADDR_W'(512 + i); wb_data = DATA_W'(i);
      #1;
      check("l5_state", fsm_state, S_RUN);
      check("l5_no_done", layer_done, 0);
      if ((i % 2) == 0) check("l5_wready", wb_ready, 1);
    end
    tick(); wb_valid = 0; #1;
    check("l5_drain", fsm_state, S_DRAIN);
    check("l5_drain_done", layer_done, 0);
    tick(); #1;
    check("l5_done", layer_done, 1);
    check("l5_done_st", fsm_state, S_DONE);
    tick(); #1;
    check("l5_after", {layer_done, busy, fsm_state}, 0);

    // zero-length layer
    tick(); layer_start = 1; layer_wr_count = 0; #1;
    tick(); layer_start = 0; #1;
    check("z_done", {layer_done, busy}, 2'b11);
    tick(); #1;
    check("z_after", {layer_done, busy}, 0);

    // start while busy is ignored
    tick(); layer_start = 1; layer_wr_count = 3; #1;
    tick(); layer_start = 0; wb_valid = 1; wb_addr = 10'h300; #1;
    check("ig_w1", wb_ready, 1);
    tick(); wb_valid = 0; layer_start = 1; layer_wr_count = 1; #1;
    check("ig_run0", fsm_state, S_RUN);
    tick(); layer_start = 0; wb_valid = 1; wb_addr = 10'h301; #1;
    check("ig_run1", fsm_state, S_RUN);
    tick(); wb_addr = 10'h302; #1;
    check("ig_run2", fsm_state, S_RUN);
    tick(); wb_valid = 0; #1;
    check("ig_drain", fsm_state, S_DRAIN);
    tick(); #1;
    check("ig_done", layer_done, 1);
    tick(); #1;
    check("ig_idle", fsm_state, S_IDLE);

    // reset in the middle of a layer
    tick(); layer_start = 1; layer_wr_count = 5; #1;
    tick(); layer_start = 0; wb_valid = 1; wb_addr = 10'h3F0; wb_data = 16'h0BAD; #1;
    tick(); wb_addr = 10'h3F1; #1;
    tick(); wb_valid = 0; reset = 1; #1;
    check("mr_pre_run", fsm_state, S_RUN);
    tick(); #1;
    check("mr_sram", {sram_en, sram_wen, sram_addr, sram_wdata}, 0);
    check("mr_rd", {rd_data_valid, rd_data}, 0);
    check("mr_ctl", {layer_done, busy, fsm_state, wb_ready, rd_ready}, 0);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("mr_quiet", {layer_done, busy}, 0);
    end
    tick(); layer_start = 1; layer_wr_count = 1; #1;
    tick(); layer_start = 0; wb_valid = 1; wb_addr = 10'h3F2; #1;
    check("mr_l1_w", wb_ready, 1);
    tick(); wb_valid = 0; #1;
    check("mr_l1_drain", fsm_state, S_DRAIN);
    tick(); #1;
    check("mr_l1_done", layer_done, 1);
    tick(); #1;
    check("mr_l1_idle", {layer_done, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
